// File: rtl/util_fifo_stepup.sv
// Width-up FIFO: packs OUTPUT_SCALE narrow writes into one wide FWFT read word.
// Optional zero-padding flush port enabled by defining UTIL_FIFO_STEPUP_FLUSH_EN.
module util_fifo_stepup #(
    parameter  int unsigned INPUT_WIDTH    = 32,
    parameter  int unsigned OUTPUT_SCALE   = 4,
    parameter  int unsigned DEPTH          = 128,
    localparam int unsigned PHYSICAL_DEPTH = DEPTH * OUTPUT_SCALE,
    localparam int unsigned OUTPUT_WIDTH   = INPUT_WIDTH * OUTPUT_SCALE,
    localparam int unsigned AW             = $clog2(PHYSICAL_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUT_WIDTH-1:0]  din,
    input  logic                    wren,
    input  logic                    rden,
`ifdef UTIL_FIFO_STEPUP_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [OUTPUT_WIDTH-1:0] dout,
    output logic [AW:0]             dcnt,
    output logic                    full,
    output logic                    empty
);

    logic [INPUT_WIDTH-1:0] r_mem [PHYSICAL_DEPTH];
    logic [AW:0]            r_w_cnt;
    logic [AW:0]            r_r_cnt;
    logic [AW:0]            w_dcnt;
    logic [AW:0]            w_w_cnt_inc;
    logic [AW:0]            w_w_cnt_nxt;
    logic [AW-1:0]          w_w_ptr;
    logic [AW-1:0]          w_r_ptr;
    logic                   w_wr;
    logic                   w_rd;

    assign w_dcnt  = r_w_cnt - r_r_cnt;
    assign dcnt    = w_dcnt;
    assign full    = w_dcnt[AW];
    assign empty   = (w_dcnt < (AW+1)'(OUTPUT_SCALE));
    assign w_wr    = wren & ~full;
    assign w_rd    = rden & ~empty;
    assign w_w_ptr = r_w_cnt[AW-1:0];
    assign w_r_ptr = r_r_cnt[AW-1:0];

    assign w_w_cnt_inc = r_w_cnt + {{AW{1'b0}}, w_wr};

`ifdef UTIL_FIFO_STEPUP_FLUSH_EN
    logic [AW:0]   w_fill;
    logic          w_pad;
    logic [AW-1:0] w_blk_base;

    // Padding is judged after any same-cycle write, so that write lands first
    assign w_fill      = w_w_cnt_inc & (AW+1)'(OUTPUT_SCALE - 1);
    assign w_pad       = flush && (w_fill != '0);
    assign w_blk_base  = w_w_cnt_inc[AW-1:0] & ~AW'(OUTPUT_SCALE - 1);
    assign w_w_cnt_nxt = w_pad ? ((w_w_cnt_inc & ~(AW+1)'(OUTPUT_SCALE - 1)) + (AW+1)'(OUTPUT_SCALE))
                               : w_w_cnt_inc;
`else
    assign w_w_cnt_nxt = w_w_cnt_inc;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_w_ptr] <= din;
        end
`ifdef UTIL_FIFO_STEPUP_FLUSH_EN
        for (int unsigned i = 0; i < OUTPUT_SCALE; i++) begin
            if (w_pad && (i >= w_fill)) begin
                r_mem[w_blk_base | AW'(i)] <= '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_cnt <= '0;
            r_r_cnt <= '0;
        end else begin
            r_w_cnt <= w_w_cnt_nxt;
            if (w_rd) begin
                r_r_cnt <= r_r_cnt + (AW+1)'(OUTPUT_SCALE);
            end
        end
    end

    // First-written narrow word lands in the least significant slice
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < OUTPUT_SCALE; i++) begin
            dout[i*INPUT_WIDTH +: INPUT_WIDTH] = r_mem[w_r_ptr + AW'(i)];
        end
    end

endmodule
